ecc_mem_scrub: RTL and testbench



---
 rtl/ecc_mem_pkg.sv | 20 ++
 rtl/ecc_mem_array.sv | 28 ++
 rtl/ecc_mem_scrub.sv | 187 ++++++++++++++++++
 tb/tb_ecc_mem_scrub.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_mem_pkg.sv
// Shared widths, FSM state codes and helpers for the SECDED-protected scrubbed memory.
package ecc_mem_pkg;

  localparam int DW   = 32;
  localparam int CW   = 39;
  localparam int CNTW = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_INIT  = 2'd0;
  localparam state_t ST_IDLE  = 2'd1;
  localparam state_t ST_CHECK = 2'd2;
  localparam state_t ST_WB    = 2'd3;

  // Error counters stick at all-ones rather than wrapping back to zero.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ecc_mem_array.sv
// DEPTH x 39-bit codeword store: one write port, one registered read port, no reset.
module ecc_mem_array
  import ecc_mem_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [CW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [CW-1:0] rdata
);

  logic [CW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ecc_mem_scrub.sv
// SECDED word memory wrapper: host reads/writes through an external codec, single-bit
// errors are written back corrected, and a background timer walks the array scrubbing it.
module ecc_mem_scrub
  import ecc_mem_pkg::*;
#(
  parameter int DEPTH          = 32,
  parameter int AW             = 5,
  parameter int SCRUB_INTERVAL = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic [DW-1:0]   enc_data,
  input  logic [CW-1:0]   enc_code,
  output logic [CW-1:0]   dec_code,
  input  logic [DW-1:0]   dec_data,
  input  logic            dec_s_err,
  input  logic            dec_d_err,
  output logic [CNTW-1:0] ce_count,
  output logic [CNTW-1:0] ue_count,
  output logic [AW-1:0]   ue_addr
);

  localparam int TW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [TW-1:0] TIMER_LAST = (SCRUB_INTERVAL > 0) ? TW'(SCRUB_INTERVAL - 1) : '0;

  state_t        state;
  logic [AW-1:0] init_ptr;
  logic [AW-1:0] scrub_ptr;
  logic          scrub_pend;
  logic [TW-1:0] scrub_timer;
  logic [AW-1:0] addr_q;
  logic          scrub_q;
  logic [DW-1:0] corr_q;

  logic          accept;
  logic          scrub_go;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic          mem_re;
  logic [AW-1:0] mem_raddr;
  logic [CW-1:0] mem_rdata;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign scrub_go  = req_ready && !req_valid && scrub_pend;
  assign dec_code  = (state == ST_CHECK) ? mem_rdata : '0;

  // The array write is gated by rst so a writeback in flight when reset hits is dropped.
  always_comb begin
    enc_data  = '0;
    mem_we    = 1'b0;
    mem_waddr = init_ptr;
    mem_re    = 1'b0;
    mem_raddr = req_addr;
    case (state)
      ST_INIT: begin
        mem_we = 1'b1;
      end
      ST_IDLE: begin
        enc_data = req_wdata;
        if (accept) begin
          if (req_we) begin
            mem_we    = 1'b1;
            mem_waddr = req_addr;
          end else begin
            mem_re = 1'b1;
          end
        end else if (scrub_pend) begin
          mem_re    = 1'b1;
          mem_raddr = scrub_ptr;
        end
      end
      ST_WB: begin
        enc_data  = corr_q;
        mem_we    = 1'b1;
        mem_waddr = addr_q;
      end
      default: begin
      end
    endcase
    if (rst) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      init_ptr  <= '0;
      scrub_ptr <= '0;
      addr_q    <= '0;
      scrub_q   <= 1'b0;
      corr_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      ce_count  <= '0;
      ue_count  <= '0;
      ue_addr   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == AW'(DEPTH - 1)) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (accept && !req_we) begin
            addr_q  <= req_addr;
            scrub_q <= 1'b0;
            state   <= ST_CHECK;
          end else if (scrub_go) begin
            addr_q  <= scrub_ptr;
            scrub_q <= 1'b1;
            state   <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (scrub_q) begin
            scrub_ptr <= scrub_ptr + 1'b1;
          end else begin
            rsp_valid <= 1'b1;
            rsp_rdata <= dec_data;
            rsp_err   <= dec_d_err;
          end
          if (dec_s_err) begin
            corr_q   <= dec_data;
            ce_count <= sat_inc(ce_count);
            state    <= ST_WB;
          end else if (dec_d_err) begin
            ue_count <= sat_inc(ue_count);
            ue_addr  <= addr_q;
            state    <= ST_IDLE;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // A pend raised while one is already waiting simply stays set; a new pend
  // landing in the same cycle a scrub is issued wins over the clear.
  always_ff @(posedge clk) begin
    if (rst || SCRUB_INTERVAL == 0) begin
      scrub_timer <= '0;
      scrub_pend  <= 1'b0;
    end else if (state != ST_INIT) begin
      if (scrub_go) begin
        scrub_pend <= 1'b0;
      end
      if (scrub_timer == TIMER_LAST) begin
        scrub_timer <= '0;
        scrub_pend  <= 1'b1;
      end else begin
        scrub_timer <= scrub_timer + 1'b1;
      end
    end
  end

  ecc_mem_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(enc_code),
    .re   (mem_re),
    .raddr(mem_raddr),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_ecc_mem_scrub.sv
// Bench for ecc_mem_scrub: supplies a Hamming(39,32) SECDED codec, injects codeword bit flips
// through the encoder path, and checks host, reset and scrub behaviour against a word-level model.
module tb_ecc_mem_scrub;

  typedef struct packed {
    logic [31:0] data;
    logic        s_err;
    logic        d_err;
  } dec_res_t;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [38:0] inj;
    logic        chk_data;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_wb;
    logic [15:0] exp_ce;
    logic [15:0] exp_ue;
    logic [4:0]  exp_ue_addr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_we = 1'b0, req_ready, rsp_valid, rsp_err;
  logic [4:0]  req_addr = '0, ue_addr;
  logic [31:0] req_wdata = '0, rsp_rdata, enc_data, dec_data;
  logic [38:0] enc_code, dec_code, inj = '0;
  logic        dec_s_err, dec_d_err;
  logic [15:0] ce_count, ue_count;
  dec_res_t    dec_res;

  logic        s_req_valid = 1'b0, s_req_we = 1'b0, s_req_ready, s_rsp_valid, s_rsp_err;
  logic [4:0]  s_req_addr = '0, s_ue_addr;
  logic [31:0] s_req_wdata = '0, s_rsp_rdata, s_enc_data, s_dec_data;
  logic [38:0] s_enc_code, s_dec_code, s_inj = '0;
  logic        s_dec_s_err, s_dec_d_err;
  logic [15:0] s_ce_count, s_ue_count;
  dec_res_t    s_dec_res;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_data [32];
  int          m_flips [32];
  int          m_ce, m_ue;
  logic [4:0]  m_ue_addr;

  // Reference SECDED codec: parity at power-of-two positions 1..32, overall parity in bit 0.
  function automatic logic [38:0] secded_enc(input logic [31:0] d);
    logic [38:0] c;
    logic        x;
    int          k;
    c = '0;
    k = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[k];
        k++;
      end
    end
    for (int i = 0; i < 6; i++) begin
      x = 1'b0;
      for (int p = 1; p <= 38; p++) begin
        if (((p >> i) & 1) == 1) x = x ^ c[p];
      end
      c[1 << i] = x;
    end
    c[0] = ^c[38:1];
    return c;
  endfunction

  function automatic dec_res_t secded_dec(input logic [38:0] code);
    dec_res_t    r;
    logic [38:0] c;
    logic [5:0]  syn;
    int          k;
    c   = code;
    syn = '0;
    r   = '0;
    for (int p = 1; p <= 38; p++) begin
      if (c[p]) syn = syn ^ 6'(p);
    end
    if (^c) begin
      if (int'(syn) <= 38) begin
        r.s_err = 1'b1;
        if (syn != 0) c[int'(syn)] = ~c[int'(syn)];
      end else begin
        r.d_err = 1'b1;
      end
    end else if (syn != 0) begin
      r.d_err = 1'b1;
    end
    k = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        r.data[k] = c[p];
        k++;
      end
    end
    return r;
  endfunction

  assign enc_code    = secded_enc(enc_data) ^ inj;
  assign dec_res     = secded_dec(dec_code);
  assign dec_data    = dec_res.data;
  assign dec_s_err   = dec_res.s_err;
  assign dec_d_err   = dec_res.d_err;

  assign s_enc_code  = secded_enc(s_enc_data) ^ s_inj;
  assign s_dec_res   = secded_dec(s_dec_code);
  assign s_dec_data  = s_dec_res.data;
  assign s_dec_s_err = s_dec_res.s_err;
  assign s_dec_d_err = s_dec_res.d_err;

  ecc_mem_scrub #(.DEPTH(32), .AW(5), .SCRUB_INTERVAL(0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .enc_data(enc_data), .enc_code(enc_code),
    .dec_code(dec_code), .dec_data(dec_data), .dec_s_err(dec_s_err), .dec_d_err(dec_d_err),
    .ce_count(ce_count), .ue_count(ue_count), .ue_addr(ue_addr)
  );

  ecc_mem_scrub #(.DEPTH(32), .AW(5), .SCRUB_INTERVAL(16)) dut_scrub (
    .clk(clk), .rst(rst),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_we(s_req_we),
    .req_addr(s_req_addr), .req_wdata(s_req_wdata),
    .rsp_valid(s_rsp_valid), .rsp_rdata(s_rsp_rdata), .rsp_err(s_rsp_err),
    .enc_data(s_enc_data), .enc_code(s_enc_code),
    .dec_code(s_dec_code), .dec_data(s_dec_data), .dec_s_err(s_dec_s_err), .dec_d_err(s_dec_d_err),
    .ce_count(s_ce_count), .ue_count(s_ue_count), .ue_addr(s_ue_addr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 64) begin
      tick();
      n++;
    end
    if (!req_ready) checkOutput("ready_timeout", 64'(req_ready), 64'(1));
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [38:0] m);
    wait_ready();
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    inj       = m;
    tick();
    req_valid = 1'b0;
    req_we    = 1'b0;
    inj       = '0;
  endtask

  task automatic do_read(input logic [4:0] a, output logic [31:0] d, output logic err,
                         output logic wb, output logic pulse_ok);
    logic v1, v2, v3, r3;
    wait_ready();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
    v1 = rsp_valid;
    tick();
    v2  = rsp_valid;
    d   = rsp_rdata;
    err = rsp_err;
    wb  = !req_ready;
    tick();
    v3 = rsp_valid;
    r3 = req_ready;
    pulse_ok = !v1 && v2 && !v3 && r3;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_data[i]  = '0;
      m_flips[i] = 0;
    end
    m_ce = 0;
    m_ue = 0;
    m_ue_addr = '0;
  endtask

  task automatic model_write(input logic [4:0] a, input logic [31:0] d, input int flips);
    m_data[a]  = d;
    m_flips[a] = flips;
  endtask

  task automatic model_read(input logic [4:0] a, output logic [31:0] d, output logic err,
                            output logic wb);
    d   = m_data[a];
    err = (m_flips[a] >= 2);
    wb  = (m_flips[a] == 1);
    if (m_flips[a] == 1) begin
      if (m_ce < 65535) m_ce++;
      m_flips[a] = 0;
    end else if (m_flips[a] >= 2) begin
      if (m_ue < 65535) m_ue++;
      m_ue_addr = a;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [31:0] d, md;
    logic        err, wb, pok, merr, mwb;
    if (v.we) begin
      do_write(v.addr, v.wdata, v.inj);
      model_write(v.addr, v.wdata, $countones(v.inj));
    end else begin
      do_read(v.addr, d, err, wb, pok);
      model_read(v.addr, md, merr, mwb);
      if (v.chk_data) checkOutput($sformatf("vec%0d_rdata", idx), 64'(d), 64'(v.exp_rdata));
      checkOutput($sformatf("vec%0d_rsp_err", idx), 64'(err), 64'(v.exp_err));
      checkOutput($sformatf("vec%0d_wb", idx), 64'(wb), 64'(v.exp_wb));
      checkOutput($sformatf("vec%0d_pulse", idx), 64'(pok), 64'(1));
    end
    checkOutput($sformatf("vec%0d_ce", idx), 64'(ce_count), 64'(v.exp_ce));
    checkOutput($sformatf("vec%0d_ue", idx), 64'(ue_count), 64'(v.exp_ue));
    checkOutput($sformatf("vec%0d_ue_addr", idx), 64'(ue_addr), 64'(v.exp_ue_addr));
  endtask

  function automatic vec_t mk(input logic we, input logic [4:0] a, input logic [31:0] wd,
                              input logic [38:0] m, input logic chk, input logic [31:0] rd,
                              input logic err, input logic wb, input logic [15:0] ce,
                              input logic [15:0] ue, input logic [4:0] uea);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = wd; v.inj = m; v.chk_data = chk; v.exp_rdata = rd;
    v.exp_err = err; v.exp_wb = wb; v.exp_ce = ce; v.exp_ue = ue; v.exp_ue_addr = uea;
    return v;
  endfunction

  function automatic logic [38:0] make_inj(input int nflips);
    logic [38:0] m;
    int b1, b2;
    m = '0;
    b1 = $urandom_range(38);
    if (nflips >= 1) m[b1] = 1'b1;
    if (nflips >= 2) begin
      b2 = $urandom_range(38);
      while (b2 == b1) b2 = $urandom_range(38);
      m[b2] = 1'b1;
    end
    return m;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs [16];
    logic [31:0] d, md, sdata [32];
    logic        err, wb, pok, merr, mwb;
    logic [4:0]  a;
    int          n, nf, r, cyc, ce_cyc, n_scrub, stream_low;
    logic        prev_ready;

    vecs[0]  = mk(1, 3,  32'hDEADBEEF, 39'd0,                   0, 32'h0,        0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 3,  32'h0,        39'd0,                   1, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 3,  32'hDEADBEEF, 39'd1 << 5,              0, 32'h0,        0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 3,  32'h0,        39'd0,                   1, 32'hDEADBEEF, 0, 1, 1, 0, 0);
    vecs[4]  = mk(0, 3,  32'h0,        39'd0,                   1, 32'hDEADBEEF, 0, 0, 1, 0, 0);
    vecs[5]  = mk(1, 9,  32'h12345678, (39'd1 << 3) | (39'd1 << 10), 0, 32'h0,   0, 0, 1, 0, 0);
    vecs[6]  = mk(0, 9,  32'h0,        39'd0,                   0, 32'h0,        1, 0, 1, 1, 9);
    vecs[7]  = mk(1, 0,  32'hA5A5A5A5, 39'd1,                   0, 32'h0,        0, 0, 1, 1, 9);
    vecs[8]  = mk(0, 0,  32'h0,        39'd0,                   1, 32'hA5A5A5A5, 0, 1, 2, 1, 9);
    vecs[9]  = mk(1, 31, 32'hFFFFFFFF, 39'd1 << 38,             0, 32'h0,        0, 0, 2, 1, 9);
    vecs[10] = mk(0, 31, 32'h0,        39'd0,                   1, 32'hFFFFFFFF, 0, 1, 3, 1, 9);
    vecs[11] = mk(0, 7,  32'h0,        39'd0,                   1, 32'h0,        0, 0, 3, 1, 9);
    vecs[12] = mk(1, 30, 32'h0,        (39'd1 << 1) | (39'd1 << 2), 0, 32'h0,    0, 0, 3, 1, 9);
    vecs[13] = mk(0, 30, 32'h0,        39'd0,                   0, 32'h0,        1, 0, 3, 2, 30);
    vecs[14] = mk(0, 9,  32'h0,        39'd0,                   0, 32'h0,        1, 0, 3, 3, 9);
    vecs[15] = mk(0, 3,  32'h0,        39'd0,                   1, 32'hDEADBEEF, 0, 0, 3, 3, 9);

    $display("[TB] reset and INIT sequence");
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 5'd7;
    tick(); tick(); tick();
    checkOutput("rst_req_ready", 64'(req_ready), 64'(0));
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    checkOutput("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    checkOutput("rst_rsp_err", 64'(rsp_err), 64'(0));
    checkOutput("rst_ce_count", 64'(ce_count), 64'(0));
    checkOutput("rst_ue_count", 64'(ue_count), 64'(0));
    checkOutput("rst_ue_addr", 64'(ue_addr), 64'(0));
    checkOutput("rst_enc_data", 64'(enc_data), 64'(0));
    checkOutput("rst_dec_code", 64'(dec_code), 64'(0));
    rst = 1'b0;
    n = 0;
    while (!req_ready && n < 100) begin
      n++;
      tick();
    end
    checkOutput("init_cycles", 64'(n), 64'(32));
    tick();
    req_valid = 1'b0;
    checkOutput("first_read_t1_valid", 64'(rsp_valid), 64'(0));
    tick();
    checkOutput("first_read_t2_valid", 64'(rsp_valid), 64'(1));
    checkOutput("first_read_rdata", 64'(rsp_rdata), 64'(0));
    checkOutput("first_read_err", 64'(rsp_err), 64'(0));
    model_reset();

    $display("[TB] directed vector table");
    for (int i = 0; i < 16; i++) applyStimulus(vecs[i], i);

    $display("[TB] randomized traffic against reference model");
    for (int i = 0; i < 150; i++) begin
      a = 5'($urandom_range(31));
      if ($urandom_range(1) == 1) begin
        d  = $urandom;
        r  = $urandom_range(9);
        nf = (r <= 5) ? 0 : ((r <= 8) ? 1 : 2);
        do_write(a, d, make_inj(nf));
        model_write(a, d, nf);
      end else begin
        do_read(a, d, err, wb, pok);
        model_read(a, md, merr, mwb);
        if (!merr) checkOutput($sformatf("rand%0d_rdata", i), 64'(d), 64'(md));
        checkOutput($sformatf("rand%0d_err", i), 64'(err), 64'(merr));
        checkOutput($sformatf("rand%0d_wb", i), 64'(wb), 64'(mwb));
        checkOutput($sformatf("rand%0d_pulse", i), 64'(pok), 64'(1));
        checkOutput($sformatf("rand%0d_ce", i), 64'(ce_count), 64'(m_ce));
        checkOutput($sformatf("rand%0d_ue", i), 64'(ue_count), 64'(m_ue));
        checkOutput($sformatf("rand%0d_ue_addr", i), 64'(ue_addr), 64'(m_ue_addr));
      end
    end

    $display("[TB] reset asserted during CHECK of a host read");
    wait_ready();
    req_valid = 1'b1;
    req_addr  = 5'd3;
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid) n++;
      tick();
    end
    checkOutput("rst_check_no_rsp", 64'(n), 64'(0));
    checkOutput("rst_check_init", 64'(req_ready), 64'(0));
    model_reset();

    $display("[TB] reset asserted during writeback");
    do_write(5'd4, 32'h0BADF00D, 39'd1 << 12);
    wait_ready();
    req_valid = 1'b1;
    req_addr  = 5'd4;
    tick();
    req_valid = 1'b0;
    tick();
    checkOutput("wb_entered", 64'(req_ready), 64'(0));
    rst = 1'b1;
    tick();
    checkOutput("rst_wb_rsp_valid", 64'(rsp_valid), 64'(0));
    checkOutput("rst_wb_ce", 64'(ce_count), 64'(0));
    rst = 1'b0;
    n = 0;
    while (!req_ready && n < 100) begin
      if (rsp_valid) checkOutput("rst_wb_late_rsp", 64'(rsp_valid), 64'(0));
      n++;
      tick();
    end
    checkOutput("reinit_cycles", 64'(n), 64'(32));
    model_reset();
    for (int i = 0; i < 32; i++) begin
      do_read(5'(i), d, err, wb, pok);
      checkOutput($sformatf("scan%0d_rdata", i), 64'({d, err, wb, pok}), 64'({32'h0, 1'b0, 1'b0, 1'b1}));
    end
    checkOutput("scan_ce", 64'(ce_count), 64'(0));

    $display("[TB] background scrub with interval 16");
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n = 0;
    while (!s_req_ready && n < 100) begin
      n++;
      tick();
    end
    checkOutput("scrub_init_cycles", 64'(n), 64'(32));
    stream_low = 0;
    for (int k = 0; k < 32; k++) begin
      sdata[k]    = 32'h5A000001 + 32'(k) * 32'h00010101;
      if (!s_req_ready) stream_low++;
      s_req_valid = 1'b1;
      s_req_we    = 1'b1;
      s_req_addr  = 5'(k);
      s_req_wdata = sdata[k];
      s_inj       = (k == 0) ? (39'd1 << 20) : 39'd0;
      tick();
    end
    s_req_valid = 1'b0;
    s_req_we    = 1'b0;
    s_inj       = '0;
    checkOutput("scrub_deferred_by_stream", 64'(stream_low), 64'(0));
    prev_ready = s_req_ready;
    cyc = 0;
    ce_cyc = -1;
    n_scrub = 0;
    while (n_scrub < 33 && cyc < 800) begin
      tick();
      cyc++;
      if (ce_cyc < 0 && s_ce_count == 16'd1) ce_cyc = cyc;
      if (prev_ready && !s_req_ready) begin
        if (n_scrub == 0) checkOutput("scrub_first_idle_issue", 64'(cyc), 64'(1));
        checkOutput($sformatf("scrub%0d_entry", n_scrub), 64'(s_dec_data), 64'(sdata[n_scrub % 32]));
        n_scrub++;
      end
      prev_ready = s_req_ready;
    end
    checkOutput("scrub_count", 64'(n_scrub), 64'(33));
    checkOutput("scrub_ce_within_20", 64'(ce_cyc > 0 && ce_cyc <= 20), 64'(1));
    checkOutput("scrub_ce_final", 64'(s_ce_count), 64'(1));
    checkOutput("scrub_ue_final", 64'(s_ue_count), 64'(0));
    checkOutput("scrub_no_rsp", 64'(s_rsp_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
